// File: rtl/lfsr_pkg.sv
`default_nettype none
// ---- lfsr_pkg : LFSR mode constants, default 22-bit polynomial/seed and single-shift function ----
// ---- Rev 1.0 ----
package lfsr_pkg;

  localparam int MODE_FIB = 0;
  localparam int MODE_GAL = 1;

  localparam logic [21:0] DEF_TAPS = 22'h206080;
  localparam logic [21:0] DEF_SEED = 22'h3FFFFF;

  // One shift of a width-bit register held in the low bits of a 32-bit word.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s,
                                            input logic [31:0] taps,
                                            input int          mode,
                                            input int          width);
    logic [32:0] wide;
    logic [31:0] mask;
    logic [31:0] r;
    wide = (33'd1 << width) - 33'd1;
    mask = wide[31:0];
    if (mode == MODE_GAL) begin
      r = (s << 1) ^ (s[width-1] ? ((taps << 1) | 32'd1) : 32'd0);
    end else begin
      r = (s << 1) | {31'd0, ^(s & taps & mask)};
    end
    return r & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_stepper.sv
`default_nettype none
// ---- lfsr_stepper : combinational STEPS-deep unroll of lfsr_step ----
// ---- Rev 1.0 ----
module lfsr_stepper
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 22,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS),
  parameter int               STEPS = 1,
  parameter int               MODE  = MODE_FIB
) (
  input  logic [WIDTH-1:0] state_in,
  output logic [WIDTH-1:0] state_out
);

  logic [WIDTH-1:0] acc;

  always_comb begin
    acc = state_in;
    for (int i = 0; i < STEPS; i++) begin
      acc = WIDTH'(lfsr_step(32'(acc), 32'(TAPS), MODE, WIDTH));
    end
    state_out = acc;
  end

endmodule
`default_nettype wire

// File: rtl/lfsr_gen.sv
`default_nettype none
// ---- lfsr_gen : Fibonacci/Galois LFSR source with seed load, lock-up recovery and valid/ready output ----
// ---- Rev 1.0 ----
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 22,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED),
  parameter int               STEPS = 1,
  parameter int               MODE  = MODE_FIB
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    load,
  input  logic [WIDTH-1:0]        seed_in,
  input  logic                    y_ready,
  output logic                    y_valid,
  output logic signed [WIDTH-1:0] y,
  output logic                    lockup,
  output logic                    seed_match
);

  if ((WIDTH < 3) || (WIDTH > 32)) begin : g_bad_width
    $error("lfsr_gen: WIDTH must be in 3..32");
  end
  if (TAPS[WIDTH-1] != 1'b1) begin : g_bad_taps
    $error("lfsr_gen: TAPS[WIDTH-1] must be set");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_gen: SEED must be nonzero");
  end
  if ((STEPS < 1) || (STEPS > WIDTH)) begin : g_bad_steps
    $error("lfsr_gen: STEPS must be in 1..WIDTH");
  end
  if ((MODE != MODE_FIB) && (MODE != MODE_GAL)) begin : g_bad_mode
    $error("lfsr_gen: MODE must be 0 or 1");
  end

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] next_state;
  logic [WIDTH-1:0] next_safe;
  logic             next_zero;
  logic             adv;

  lfsr_stepper #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .STEPS (STEPS),
    .MODE  (MODE)
  ) u_stepper (
    .state_in  (state),
    .state_out (next_state)
  );

  // An advance only happens when the output slot is free or being emptied this cycle.
  assign adv       = en & ~load & (~y_valid | y_ready);
  assign next_zero = (next_state == '0);
  assign next_safe = next_zero ? SEED : next_state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= SEED;
      y          <= '0;
      y_valid    <= 1'b0;
      lockup     <= 1'b0;
      seed_match <= 1'b0;
    end else begin
      lockup     <= 1'b0;
      seed_match <= 1'b0;
      if (load) begin
        if (seed_in == '0) begin
          state  <= SEED;
          lockup <= 1'b1;
        end else begin
          state <= seed_in;
        end
        y_valid <= 1'b0;
      end else if (adv) begin
        state      <= next_safe;
        y          <= next_safe;
        y_valid    <= 1'b1;
        lockup     <= next_zero;
        seed_match <= (next_safe == SEED);
      end else if (y_ready) begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
